// File: rtl/data_mem_responder_if.sv
// Bus between an initiator and the data memory responder: a request with
// captured write data, answered by a one-cycle ack that carries rdata/err.
`timescale 1ns/1ps
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/data_mem_responder.sv
// Single-port word RAM plus a read-only free-running cycle counter behind a
// three-state request/ack responder (IDLE -> ACCESS -> RESP).
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus,
    output logic [1:0]            state_dbg
);
    // Handshake: req is sampled only in IDLE (busy=0); on acceptance we/addr/wdata
    // are captured and later input changes are ignored. Exactly one ack pulse
    // follows two edges later; rdata/err are meaningful only while ack=1.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  ACCESS   = 2'd1;
    localparam logic [1:0]  RESP     = 2'd2;
    localparam logic [31:0] CNT_ADDR = 32'h0000_0100;

    logic [1:0]    state;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   cnt;
    logic [31:0]   mem [DEPTH];

    logic          ram_hit;
    logic          cnt_hit;
    logic [AW-1:0] ram_idx;

    assign ram_hit = (addr_q < 32'(DEPTH));
    assign cnt_hit = (addr_q == CNT_ADDR);
    assign ram_idx = addr_q[AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (ram_hit) begin
                        rdata_q <= we_q ? 32'd0 : mem[ram_idx];
                        err_q   <= 1'b0;
                    end else if (cnt_hit) begin
                        // Report the value the counter takes at this same edge.
                        rdata_q <= we_q ? 32'd0 : cnt + 32'd1;
                        err_q   <= we_q;
                    end else begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 32'd0;
        else      cnt <= cnt + 32'd1;
    end

    // No reset on the array: contents survive rst, and a reset before the
    // ACCESS edge drops state to IDLE so a pending write never lands.
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && ram_hit)
            mem[ram_idx] <= wdata_q;
    end

    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign bus.ack   = (state == RESP);
    assign bus.busy  = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table of single transactions
// plus hand sequences for counter, wrap, held request and mid-write reset.
`timescale 1ns/1ps
module tb_data_mem_responder;
  localparam int DEPTH = 16;

  typedef struct {
    string       name;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present a request at a negedge, drop it (and scramble the
  // captured fields) just after the accepting edge
  task automatic launch(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1;
    bus.req = 1'b0; bus.we = ~w; bus.addr = $urandom; bus.wdata = $urandom;
  endtask

  // count negedges after the accepting edge until ack (bounded)
  task automatic wait_ack(output logic [31:0] rd, output logic e, output int lat);
    lat = 0; rd = 32'd0; e = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.ack) begin
        lat = i; rd = bus.rdata; e = bus.err;
        break;
      end
    end
  endtask

  task automatic txn(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e);
    int lat;
    launch(w, a, d);
    wait_ack(rd, e, lat);
    chk({name, "_lat"}, 32'(lat), 32'd2);
  endtask

  vec_t        vecs[12];
  logic [31:0] rd;
  logic        e;
  int          lat;
  logic [31:0] c1, c2, c3;
  logic [5:0]  ack_pat;

  initial begin
    vecs[0]  = '{"wr5",     1'b1, 32'd5,          32'hDEAD_BEEF, 32'd0,         1'b0};
    vecs[1]  = '{"rd5",     1'b0, 32'd5,          32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{"wr_top",  1'b1, 32'd15,         32'h0000_0001, 32'd0,         1'b0};
    vecs[3]  = '{"rd_top",  1'b0, 32'd15,         32'h0,         32'h0000_0001, 1'b0};
    vecs[4]  = '{"rd_dep",  1'b0, 32'd16,         32'h0,         32'd0,         1'b1};
    vecs[5]  = '{"wr_dep",  1'b1, 32'd16,         32'h1111_2222, 32'd0,         1'b1};
    vecs[6]  = '{"wr_cnt",  1'b1, 32'h100,        32'h5555_5555, 32'd0,         1'b1};
    vecs[7]  = '{"rd5_b",   1'b0, 32'd5,          32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{"wr0",     1'b1, 32'd0,          32'h1234_5678, 32'd0,         1'b0};
    vecs[9]  = '{"rd0",     1'b0, 32'd0,          32'h0,         32'h1234_5678, 1'b0};
    vecs[10] = '{"rd_alias",1'b0, 32'h8000_0005,  32'h0,         32'd0,         1'b1};
    vecs[11] = '{"rd_top_b",1'b0, 32'd15,         32'h0,         32'h0000_0001, 1'b0};

    checks = 0; errors = 0;
    rst = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",   32'(bus.ack),   32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);
    chk("rst_rdata", bus.rdata,      32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    #1 rst = 1'b1;

    // first accept on the first edge with rst=1: counter sampled two edges in
    txn("cnt_first", 1'b0, 32'h100, 32'd0, rd, e);
    chk("cnt_first_val", rd, 32'd2);

    foreach (vecs[i]) begin
      txn(vecs[i].name, vecs[i].w, vecs[i].a, vecs[i].d, rd, e);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
    end

    // counter: back-to-back reads, write rejected, counter keeps running
    txn("cnt_a", 1'b0, 32'h100, 32'd0, c1, e);
    txn("cnt_b", 1'b0, 32'h100, 32'd0, c2, e);
    chk("cnt_delta", c2 - c1, 32'd3);
    txn("cnt_wr", 1'b1, 32'h100, 32'hFFFF_FFFF, rd, e);
    chk("cnt_wr_err", 32'(e), 32'd1);
    chk("cnt_wr_rdata", rd, 32'd0);
    txn("cnt_c", 1'b0, 32'h100, 32'd0, c3, e);
    chk("cnt_delta2", c3 - c2, 32'd6);

    // wrap: counter preset, sampled two edges later
    @(negedge clk);
    force dut.cnt = 32'hFFFF_FFFE;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h100;
    #1 release dut.cnt;
    @(posedge clk);
    #1 bus.req = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    wait_ack(rd, e, lat);
    chk("wrap_lat", 32'(lat), 32'd2);
    chk("wrap_val", rd, 32'd0);
    chk("wrap_err", 32'(e), 32'd0);

    // req held 6 edges: acks at cycles 2 and 5 after the first accept
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'd5;
    @(posedge clk);
    ack_pat = 6'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ack_pat[k-1] = bus.ack;
    end
    bus.req = 1'b0;
    chk("held_req_acks", 32'(ack_pat), 32'(6'b010010));
    repeat (2) @(negedge clk);

    // reset in the middle of a write
    txn("pre7", 1'b1, 32'd7, 32'hAAAA_5555, rd, e);
    launch(1'b1, 32'd7, 32'h0BAD_0BAD);
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(bus.busy),  32'd0);
    chk("mid_rst_ack",   32'(bus.ack),   32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    ack_pat = 6'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ack_pat[k] = bus.ack;
    end
    chk("mid_rst_noack", 32'(ack_pat), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    txn("post_cnt", 1'b0, 32'h100, 32'd0, rd, e);
    chk("post_cnt_val", rd, 32'd2);
    txn("post7", 1'b0, 32'd7, 32'd0, rd, e);
    chk("post7_rdata", rd, 32'hAAAA_5555);
    chk("post7_err", 32'(e), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH, 256, number of 32-bit RAM words; power of two, 2..256.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  1  initiator request valid.
REQ-005 Port: we  input  1  1 = write, 0 = read; qualified by req.
REQ-006 Port: addr  input  32  word address (one unit per 32-bit word).
REQ-007 Port: wdata  input  32  write data.
REQ-008 Port: rdata  output  32  read data; valid only while ack=1.
REQ-009 Port: ack  output  1  one-cycle completion pulse.
REQ-010 Port: err  output  1  access error; valid only while ack=1.
REQ-011 Port: busy  output  1  1 while a transaction is in flight (not IDLE).

Function
REQ-012 Address map: 0 .. DEPTH-1 RAM (read/write); 0x0000_0100 cycle counter (read-only); all other addresses error.
REQ-013 FSM states: IDLE, ACCESS, RESP.
REQ-014 IDLE: req=1 captures we, addr, wdata into internal registers and moves to ACCESS; req=0 stays in IDLE.
REQ-015 ACCESS: RAM write or RAM read, or counter sample, using the captured values; unconditionally moves to RESP.
REQ-016 RESP: ack=1 for exactly one cycle; rdata and err driven; unconditionally moves to IDLE.
REQ-017 Latency: ack asserts 2 cycles after the accepting edge; a new request is accepted at the earliest on the edge after RESP.
REQ-018 Requests are accepted only in IDLE; req while busy=1 is ignored and does not queue.
REQ-019 req deasserted after acceptance does not cancel the transaction.
REQ-020 Captured values are final; changes to addr, we or wdata after acceptance have no effect.
REQ-021 RAM write: the word at the captured address takes the captured wdata at the ACCESS edge; rdata=0 in RESP.
REQ-022 RAM read: rdata = word at the captured address as of ACCESS; a read immediately following a write to the same address returns the new data.
REQ-023 Counter: 32-bit free-running, increments every cycle, wraps 0xFFFF_FFFF -> 0.
REQ-024 Counter read: rdata = counter value sampled at the ACCESS edge.
REQ-025 Write to the counter address: err=1, counter unaffected, rdata=0.
REQ-026 Unmapped address, read or write: err=1, rdata=0, RAM unchanged.
REQ-027 Mapped access: err=0.
REQ-028 No combinational path from any input to any output; all outputs registered or decoded from state.

Reset
REQ-029 rst=0 immediately forces IDLE, ack=0, err=0, busy=0, rdata=0, counter=0, without waiting for a clock edge.
REQ-030 RAM contents are not reset; they keep their values through reset.
REQ-031 Reset mid-transaction aborts it: no ack is produced; a write that has not yet reached its ACCESS edge is not performed.
REQ-032 First accept is possible on the first rising edge with rst=1.

Verification
REQ-033 Write then read: write addr=5, wdata=0xDEADBEEF; ack 2 cycles later with err=0; then read addr=5 -> rdata=0xDEADBEEF, err=0.
REQ-034 Boundaries: write addr=DEPTH-1 with data 0x1 -> read back 0x1; read addr=DEPTH (not 0x100) -> err=1, rdata=0.
REQ-035 Counter: read 0x100 twice back-to-back -> second value minus first value = 3; write 0x100 -> err=1, next read still increments.
REQ-036 Wrap: force counter to 0xFFFF_FFFE, read 0x100 at the sampling edge two cycles later -> rdata=0x0000_0000.
REQ-037 Req held and busy: hold req=1 continuously for 6 cycles with fixed addr -> exactly 2 ack pulses, at cycles 2 and 5 after the first accept.
REQ-038 Reset mid-write: accept write addr=7, assert rst=0 before the ACCESS edge -> no ack, busy=0 immediately, word 7 keeps its prior value.
